// File: rtl/mac_column_sequencer.sv
// Control sequencer for one column of a systolic MAC array: loads weights,
// streams activation vectors, drains the column and inserts error-compensation cycles.
module mac_column_sequencer #(
  parameter int ROWS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                vec_len,
  output logic                      busy,
  output logic                      done,
  output logic                      wt_load,
  output logic [$clog2(ROWS)-1:0]   wt_addr,
  input  logic                      act_valid,
  output logic                      act_ready,
  output logic                      mac_en,
  output logic                      psum_clear,
  input  logic                      mac_error,
  output logic                      comp_en,
  output logic                      out_valid,
  output logic [7:0]                err_count
);

  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, COMP, DRAIN, DONE} state_t;

  state_t            state, state_nxt, ret_state, ret_nxt;
  logic [7:0]        vec_len_q, acc_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [ROWS-1:0]   tok;
  logic              ov_hold;
  logic              accept, last_acc, last_drain, err_evt, adv_out, job_go;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_state;
    busy       = (state != IDLE);
    done       = 1'b0;
    wt_load    = 1'b0;
    wt_addr    = '0;
    act_ready  = 1'b0;
    mac_en     = 1'b0;
    psum_clear = 1'b0;
    comp_en    = 1'b0;
    accept     = 1'b0;
    last_acc   = 1'b0;
    last_drain = 1'b0;
    err_evt    = 1'b0;
    job_go     = 1'b0;
    case (state)
      IDLE: begin
        job_go = start && (vec_len != 8'd0);
        if (job_go) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        wt_load = 1'b1;
        wt_addr = row_cnt;
        if (row_cnt == ROW_W'(ROWS - 1)) state_nxt = STREAM;
      end
      STREAM: begin
        act_ready  = 1'b1;
        accept     = act_valid;
        mac_en     = accept;
        psum_clear = accept;
        last_acc   = accept && (acc_cnt + 8'd1 == vec_len_q);
        err_evt    = mac_error;
        // On an error the compensation cycle returns to wherever this cycle would have gone
        if (mac_error) begin
          state_nxt = COMP;
          ret_nxt   = last_acc ? DRAIN : STREAM;
        end else begin
          state_nxt = last_acc ? DRAIN : STREAM;
        end
      end
      DRAIN: begin
        mac_en     = 1'b1;
        last_drain = (row_cnt == ROW_W'(ROWS - 2));
        err_evt    = mac_error;
        if (mac_error) begin
          state_nxt = COMP;
          ret_nxt   = last_drain ? DONE : DRAIN;
        end else begin
          state_nxt = last_drain ? DONE : DRAIN;
        end
      end
      COMP: begin
        comp_en   = 1'b1;
        state_nxt = ret_state;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A result leaves row ROWS-1 when the advance carries a token from the second-to-last stage
  assign adv_out = mac_en && tok[ROWS-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ret_state <= IDLE;
      vec_len_q <= 8'd0;
      acc_cnt   <= 8'd0;
      row_cnt   <= '0;
      tok       <= '0;
      err_count <= 8'd0;
      out_valid <= 1'b0;
      ov_hold   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      if (job_go) begin
        vec_len_q <= vec_len;
        err_count <= 8'd0;
        tok       <= '0;
        acc_cnt   <= 8'd0;
        row_cnt   <= '0;
      end
      if (state == LOAD_W)
        row_cnt <= (row_cnt == ROW_W'(ROWS - 1)) ? '0 : row_cnt + ROW_W'(1);
      if (state == DRAIN)
        row_cnt <= last_drain ? '0 : row_cnt + ROW_W'(1);
      if (accept) acc_cnt <= acc_cnt + 8'd1;
      if (mac_en) tok <= {tok[ROWS-2:0], accept};
      if (err_evt) err_count <= sat_inc8(err_count);
      // A result finished on an errored cycle is held until compensation has folded in
      if (err_evt) begin
        out_valid <= 1'b0;
        ov_hold   <= adv_out;
      end else if (state == COMP) begin
        out_valid <= ov_hold;
        ov_hold   <= 1'b0;
      end else begin
        out_valid <= adv_out;
      end
    end
  end

endmodule
